// File: rtl/tiproc_mem_pkg.sv
// Shared types and defaults for the program/result memory port arbiter.
package tiproc_mem_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StRdAck,
    StWr
  } arb_state_t;

  typedef enum logic {
    GrantFetch,
    GrantRes
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and result-store requests.
// MEM_ARB_ROUND_ROBIN_EN: alternate on conflict; otherwise result-store always wins.
module mem_arb_pick
  import tiproc_mem_pkg::*;
(
  input  logic   fetch_req_i,
  input  logic   res_req_i,
  input  grant_t last_grant_i,
  output logic   grant_valid_o,
  output grant_t grant_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_valid_o = fetch_req_i | res_req_i;
    grant_o       = GrantRes;
    if (fetch_req_i && res_req_i) begin
      grant_o = (last_grant_i == GrantRes) ? GrantFetch : GrantRes;
    end else if (fetch_req_i) begin
      grant_o = GrantFetch;
    end
  end
`else
  // Fixed priority drains results first; history is kept upstream but not consulted here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_valid_o = fetch_req_i | res_req_i;
    grant_o       = GrantRes;
    if (fetch_req_i && !res_req_i) begin
      grant_o = GrantFetch;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch reads and result-store writes onto one single-port memory with ack pulses.
// Conflict policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
  import tiproc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              res_req,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_wdata,
  output logic              res_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t      state_q;
  grant_t          last_grant_q;
  logic [LatW-1:0] lat_cnt_q;

  logic   grant_valid;
  grant_t grant;

  mem_arb_pick u_pick (
    .fetch_req_i   (fetch_req),
    .res_req_i     (res_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRes;
      lat_cnt_q    <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      fetch_ack    <= 1'b0;
      fetch_rdata  <= '0;
      res_ack      <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      fetch_ack <= 1'b0;
      res_ack   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            last_grant_q <= grant;
            mem_en       <= 1'b1;
            if (grant == GrantRes) begin
              mem_addr  <= res_addr;
              mem_wdata <= res_wdata;
              mem_we    <= 1'b1;
              res_ack   <= 1'b1;
              state_q   <= StWr;
            end else begin
              mem_addr  <= fetch_addr;
              lat_cnt_q <= LatW'(MEM_LAT - 1);
              state_q   <= StRd;
            end
          end
        end
        StRd: begin
          if (lat_cnt_q == '0) begin
            fetch_rdata <= mem_rdata;
            fetch_ack   <= 1'b1;
            state_q     <= StRdAck;
          end else begin
            lat_cnt_q <= lat_cnt_q - LatW'(1);
          end
        end
        StRdAck: state_q <= StIdle;
        StWr:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  a_we_needs_en: assert property (@(posedge clock) disable iff (!reset) mem_we |-> mem_en);
  a_one_ack: assert property (@(posedge clock) disable iff (!reset) !(fetch_ack && res_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one MEM_LAT=1 arbiter for function/contention, one MEM_LAT=2 for latency/reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int enc(input string s);
    int c = 0;
    for (int i = 0; i < s.len(); i++) c = c * 4 + ((s[i] == "R") ? 1 : 2);
    return c;
  endfunction

  // DUT A: MEM_LAT = 1, combinational read model
  logic       a_fetch_req = 1'b0, a_res_req = 1'b0;
  logic [7:0] a_fetch_addr = '0, a_res_addr = '0, a_res_wdata = '0;
  logic       a_fetch_ack, a_res_ack, a_mem_en, a_mem_we, a_busy;
  logic [7:0] a_fetch_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [7:0] mem_a [256];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut_a (
    .clock       (clk),
    .reset       (rst_n),
    .fetch_req   (a_fetch_req),
    .fetch_addr  (a_fetch_addr),
    .fetch_ack   (a_fetch_ack),
    .fetch_rdata (a_fetch_rdata),
    .res_req     (a_res_req),
    .res_addr    (a_res_addr),
    .res_wdata   (a_res_wdata),
    .res_ack     (a_res_ack),
    .mem_en      (a_mem_en),
    .mem_we      (a_mem_we),
    .mem_addr    (a_mem_addr),
    .mem_wdata   (a_mem_wdata),
    .mem_rdata   (a_mem_rdata),
    .busy        (a_busy)
  );

  assign a_mem_rdata = mem_a[a_mem_addr];
  always @(posedge clk) if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;

  // DUT B: MEM_LAT = 2, one registered read stage
  logic       b_fetch_req = 1'b0;
  logic [7:0] b_fetch_addr = '0;
  logic       b_fetch_ack, b_res_ack, b_mem_en, b_mem_we, b_busy;
  logic [7:0] b_fetch_rdata, b_mem_addr, b_mem_wdata, b_rd_q;
  logic [7:0] mem_b [256];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) u_dut_b (
    .clock       (clk),
    .reset       (rst_n),
    .fetch_req   (b_fetch_req),
    .fetch_addr  (b_fetch_addr),
    .fetch_ack   (b_fetch_ack),
    .fetch_rdata (b_fetch_rdata),
    .res_req     (1'b0),
    .res_addr    (8'h00),
    .res_wdata   (8'h00),
    .res_ack     (b_res_ack),
    .mem_en      (b_mem_en),
    .mem_we      (b_mem_we),
    .mem_addr    (b_mem_addr),
    .mem_wdata   (b_mem_wdata),
    .mem_rdata   (b_rd_q),
    .busy        (b_busy)
  );

  always @(posedge clk) b_rd_q <= mem_b[b_mem_addr];

  // Holds each request level until its ack, then moves on; records ack order as a code.
  task automatic contend(input int n_res, input int n_fetch, input logic [7:0] res_addr0,
                         input logic [7:0] res_data0, input logic [7:0] faddr,
                         output int code, output logic [7:0] rdata);
    int res_done = 0;
    int fetch_done = 0;
    int cyc = 0;
    code = 0;
    rdata = '0;
    a_res_addr   = res_addr0;
    a_res_wdata  = res_data0;
    a_fetch_addr = faddr;
    a_res_req    = (n_res > 0);
    a_fetch_req  = (n_fetch > 0);
    while ((res_done < n_res || fetch_done < n_fetch) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_res_ack) begin
        code = code * 4 + 1;
        res_done++;
      end
      if (a_fetch_ack) begin
        code = code * 4 + 2;
        fetch_done++;
        rdata = a_fetch_rdata;
      end
      a_res_addr  = res_addr0 + 8'(res_done);
      a_res_wdata = res_data0 + 8'(res_done);
      a_res_req   = (res_done < n_res);
      a_fetch_req = (fetch_done < n_fetch);
    end
    if (cyc >= 60) check("contend_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
  endtask

  int         code;
  logic [7:0] rd;
  int         ack_seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[8'h10] = 8'hA5;
    mem_a[8'h30] = 8'h11;
    mem_a[8'h31] = 8'h22;
    mem_b[8'h05] = 8'h5A;
    mem_b[8'h06] = 8'h66;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_mem_en", 32'(a_mem_en), 0);
    check("rst_mem_we", 32'(a_mem_we), 0);
    check("rst_acks", {30'd0, a_fetch_ack, a_res_ack}, 0);
    check("rst_mem_addr", 32'(a_mem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, MEM_LAT=1
    a_fetch_addr = 8'h10;
    a_fetch_req  = 1'b1;
    @(negedge clk);
    check("rd_mem_en", {30'd0, a_mem_en, a_mem_we}, 32'b10);
    check("rd_mem_addr", 32'(a_mem_addr), 32'h10);
    check("rd_no_early_ack", 32'(a_fetch_ack), 0);
    check("rd_busy", 32'(a_busy), 1);
    @(negedge clk);
    check("rd_ack", 32'(a_fetch_ack), 1);
    check("rd_data", 32'(a_fetch_rdata), 32'hA5);
    check("rd_en_drop", 32'(a_mem_en), 0);
    a_fetch_req = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", {30'd0, a_fetch_ack, a_busy}, 0);
    check("rd_data_hold", 32'(a_fetch_rdata), 32'hA5);

    // Single write
    a_res_addr  = 8'h80;
    a_res_wdata = 8'h3C;
    a_res_req   = 1'b1;
    @(negedge clk);
    check("wr_strobes", {29'd0, a_mem_en, a_mem_we, a_res_ack}, 32'b111);
    check("wr_addr_data", {16'd0, a_mem_addr, a_mem_wdata}, 32'h803C);
    a_res_req = 1'b0;
    @(negedge clk);
    check("wr_after", {29'd0, a_mem_en, a_res_ack, a_busy}, 0);
    check("wr_mem", 32'(mem_a[8'h80]), 32'h3C);

    // Read with MEM_LAT=2
    b_fetch_addr = 8'h05;
    b_fetch_req  = 1'b1;
    @(negedge clk);
    check("l2_en", 32'(b_mem_en), 1);
    @(negedge clk);
    check("l2_no_ack_k2", {30'd0, b_fetch_ack, b_mem_en}, 0);
    @(negedge clk);
    check("l2_ack_k3", 32'(b_fetch_ack), 1);
    check("l2_data", 32'(b_fetch_rdata), 32'h5A);
    b_fetch_req = 1'b0;
    @(negedge clk);
    check("l2_idle", 32'(b_busy), 0);

    // Reset mid-read aborts without an ack
    b_fetch_addr = 8'h06;
    b_fetch_req  = 1'b1;
    @(negedge clk);
    check("abort_busy_before", 32'(b_busy), 1);
    rst_n       = 1'b0;
    b_fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_outs", {28'd0, b_busy, b_fetch_ack, b_mem_en, b_mem_we}, 0);
    check("abort_rdata", 32'(b_fetch_rdata), 0);
    check("abort_addr", 32'(b_mem_addr), 0);
    rst_n = 1'b1;
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_fetch_ack) ack_seen++;
    end
    check("abort_no_ack", 32'(ack_seen), 0);

    // Contention from last_grant=RES: 2 writes vs 1 read
    contend(2, 1, 8'h50, 8'h90, 8'h30, code, rd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("conflict_order_a", 32'(code), 32'(enc("FRR")));
`else
    check("conflict_order_a", 32'(code), 32'(enc("RRF")));
`endif
    check("conflict_rdata_a", 32'(rd), 32'h11);
    check("conflict_mem_a", {16'd0, mem_a[8'h50], mem_a[8'h51]}, 32'h9091);

    // Uncontended fetch leaves last_grant=FETCH
    contend(0, 1, 8'h00, 8'h00, 8'h10, code, rd);
    check("solo_fetch", 32'(code), 32'(enc("F")));
    check("solo_rdata", 32'(rd), 32'hA5);

    // Contention from last_grant=FETCH: 2 writes vs 2 reads
    contend(2, 2, 8'h60, 8'hA0, 8'h31, code, rd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("conflict_order_b", 32'(code), 32'(enc("RFRF")));
`else
    check("conflict_order_b", 32'(code), 32'(enc("RRFF")));
`endif
    check("conflict_rdata_b", 32'(rd), 32'h22);
    check("conflict_mem_b", {16'd0, mem_a[8'h60], mem_a[8'h61]}, 32'hA0A1);

    // Same address both ports: write lands before the read
    contend(1, 1, 8'h20, 8'h77, 8'h20, code, rd);
    check("same_addr_order", 32'(code), 32'(enc("RF")));
    check("same_addr_rdata", 32'(rd), 32'h77);
    check("final_idle", 32'(a_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
